// File: rtl/seq_pkg.sv
// Shared types and constants for the serial test link transmitter and detector.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    DATA,
    FIN
  } seq_tx_state_t;

  localparam logic [3:0]  SEQ_MARKER     = 4'b1010;
  localparam int unsigned SEQ_MARKER_LEN = 4;

endpackage

// File: rtl/seq_bit_selector.sv
// Picks the serial bit for a given index, either from the frame marker or the
// latched payload word.
module seq_bit_selector
  import seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 5
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  input  logic                  sel_mark_i,
  output logic                  bit_o
);

  logic data_bit;

  always_comb begin
    data_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (idx_i == IDX_WIDTH'(i)) begin
        data_bit = word_i[i];
      end
    end
  end

  assign bit_o = sel_mark_i ? SEQ_MARKER[idx_i[1:0]] : data_bit;

endmodule

// File: rtl/seq_frame_transmitter.sv
// Serial frame transmitter: optional 1010 marker followed by (repeat+1) copies
// of a len-bit payload, MSB-first, over a valid/ready bit link.
module seq_frame_transmitter
  import seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = $clog2(DATA_WIDTH + 1),
  parameter int unsigned REP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_pattern,
  input  logic [LEN_WIDTH-1:0]  din_len,
  input  logic [REP_WIDTH-1:0]  din_repeat,
  input  logic                  din_mark,
  output logic                  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  done,
  output logic                  err
);

  seq_tx_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic                  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  sel_bit;
  logic                  beat;
  logic                  len_illegal;

  assign beat        = dout_valid_q && dout_ready;
  assign len_illegal = (din_len == '0) || (din_len > LEN_WIDTH'(DATA_WIDTH));

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    len_d        = len_q;
    rep_d        = rep_q;
    idx_d        = idx_q;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          pattern_d = din_pattern;
          len_d     = din_len;
          rep_d     = din_repeat;
          if (len_illegal) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (din_mark) begin
            state_d      = MARK;
            idx_d        = LEN_WIDTH'(SEQ_MARKER_LEN - 1);
            dout_valid_d = 1'b1;
          end else begin
            state_d      = DATA;
            idx_d        = din_len - LEN_WIDTH'(1);
            dout_valid_d = 1'b1;
          end
        end
      end
      MARK: begin
        dout_valid_d = 1'b1;
        if (beat) begin
          if (idx_q == '0) begin
            state_d = DATA;
            idx_d   = len_q - LEN_WIDTH'(1);
          end else begin
            idx_d = idx_q - LEN_WIDTH'(1);
          end
        end
      end
      DATA: begin
        dout_valid_d = 1'b1;
        if (beat) begin
          if (idx_q != '0) begin
            idx_d = idx_q - LEN_WIDTH'(1);
          end else if (rep_q != '0) begin
            rep_d = rep_q - REP_WIDTH'(1);
            idx_d = len_q - LEN_WIDTH'(1);
          end else begin
            state_d      = FIN;
            dout_valid_d = 1'b0;
            done_d       = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The selector looks at next-cycle state so dout is registered alongside dout_valid.
  seq_bit_selector #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (LEN_WIDTH)
  ) u_bit_selector (
    .word_i     (pattern_d),
    .idx_i      (idx_d),
    .sel_mark_i (state_d == MARK),
    .bit_o      (sel_bit)
  );

  assign dout_d = dout_valid_d && sel_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pattern_q    <= '0;
      len_q        <= '0;
      rep_q        <= '0;
      idx_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      len_q        <= len_d;
      rep_q        <= rep_d;
      idx_q        <= idx_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign din_ready  = (state_q == IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/seq_frame_transmitter.md
# seq_frame_transmitter

Serial frame transmitter: accepts a parallel pattern word with a length and a repeat count, then emits it one bit per accepted beat on a valid/ready serial link. Each frame is optionally preceded by the `1010` frame marker, which the serial sequence detector on the far end recognises. It sits on the transmit side of the serial test link and feeds the detector / deserializer path.

## Interface
- `DATA_WIDTH`, 16: maximum payload bits per frame.
- `LEN_WIDTH`, $clog2(DATA_WIDTH+1): width of the length field.
- `REP_WIDTH`, 4: width of the repeat-count field.

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `din_valid` in 1: frame request valid.
- `din_ready` out 1: block can accept a frame request.
- `din_pattern` in DATA_WIDTH: payload; bits [len-1:0] are used.
- `din_len` in LEN_WIDTH: payload length in bits; legal range 1..DATA_WIDTH.
- `din_repeat` in REP_WIDTH: extra payload repetitions; total payloads = repeat+1.
- `din_mark` in 1: 1 = emit the 4-bit marker before the first payload.
- `dout` out 1: serial bit; 0 whenever `dout_valid`=0.
- `dout_valid` out 1: `dout` holds a bit.
- `dout_ready` in 1: sink accepts the current bit.
- `done` out 1: one-cycle pulse at frame end.
- `err` out 1: one-cycle pulse, coincident with `done`, for an illegal length.

## Operation
- States: IDLE, MARK, DATA, FIN.
- IDLE: `din_ready`=1 (decoded from state). A request is accepted when `din_valid` and `din_ready` are both high. On accept, latch pattern, len, repeat and mark.
  - mark=1 -> MARK.
  - mark=0 -> DATA.
  - len=0 or len>DATA_WIDTH -> FIN with err set; no bits are emitted and mark is ignored.
- MARK: emits marker bits 1,0,1,0 in that order. After the 4th beat is accepted -> DATA.
- DATA: emits payload MSB-first, bit len-1 down to bit 0.
  - After bit 0 is accepted: if repetitions remain, decrement the remaining count and restart at bit len-1 with no gap and no marker.
  - Otherwise -> FIN.
- FIN: lasts one cycle. `done`=1, `err` as latched, `dout_valid`=0. Next state is IDLE.
- Beat rule: a bit transfers when `dout_valid` and `dout_ready` are both high. While `dout_ready`=0, `dout` and `dout_valid` stay stable.
- `din_*` inputs are ignored outside IDLE.
- The bit index counter is LEN_WIDTH wide. The repeat counter is REP_WIDTH wide and never wraps: it stops at 0.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `done`=0, `err`=0. State is IDLE, so `din_ready`=1 on the first cycle after reset.
- `dout`, `dout_valid`, `done` and `err` are registered.
- Latency: request accepted in cycle N -> first bit valid in cycle N+1.
- With `dout_ready` held high, one bit is emitted per cycle. Frame duration = 4·mark + len·(repeat+1) beats.
- Last bit accepted in cycle M -> `done` in cycle M+1 and IDLE in cycle M+2.
- Minimum gap between frames is 2 idle link cycles: the FIN cycle plus the IDLE accept cycle.
- Reset asserted mid-frame: on the next edge all outputs return to reset values and the frame is discarded, with no `done`. Reset has priority over every other event.
- Illegal length: accepted in cycle N -> `done`=`err`=1 in cycle N+1.

## Structure
- Package `seq_pkg` holds:
  - `seq_tx_state_t` enum (IDLE, MARK, DATA, FIN);
  - `SEQ_MARKER` = 4'b1010;
  - `SEQ_MARKER_LEN` = 4.
- The detector side shares this package.
- Sub-module `seq_bit_selector` is combinational. It takes the latched word and the bit index and returns the output bit. It is shared by the MARK and DATA paths (the marker is indexed from `SEQ_MARKER`).
- The FSM, counters and output registers live in the top module.

## Test plan
- Reset → outputs: after reset, `dout_valid`=0, `done`=0, `din_ready`=1. Assert reset while a frame is in the DATA state → next cycle `dout_valid`=0, no `done`.
- Marked frame: pattern=16'h000B, len=4, mark=1, repeat=0, `dout_ready`=1 → stream 1,0,1,0,1,0,1,1; `done` one cycle after the last bit; total of 8 beats.
- Repeats: pattern=3'b110, len=3, repeat=2, mark=0 → stream 110110110; exactly one `done` pulse.
- Backpressure: `dout_ready` random at 50% on a 16-bit frame of pattern 16'hA5C3 → the bit sequence matches the pattern exactly; `dout` stays stable while stalled.
- Illegal length: len=0, then len=DATA_WIDTH+1 → no `dout_valid`; `done`=`err`=1 one cycle after accept.
- Back-to-back with loopback: frames are requested continuously and fed into the `1010` sequence detector → the detector fires once per marker, and frames are spaced by 2 idle cycles.
